// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared definitions for the instruction fetch stage.
//   fetch_state_t : sequencing state of the fetch unit (IDLE, RUN, HALTED)
//   R_BRANCH      : register index that holds the absolute branch target;
//                   shared with Control's BREG/bez/bne encoding
package fetch_unit_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HALTED
   } fetch_state_t;

   localparam logic [3:0] R_BRANCH = 4'b1000;

endpackage : fetch_unit_pkg

// File: rtl/fetch_unit_sat_counter.sv
// sat_counter: synchronous up-counter that sticks at its all-ones value.
//   CLK   : clock, rising edge
//   Reset : synchronous active-high, clears count
//   clr   : synchronous clear (below Reset in priority)
//   inc   : increment by one unless already saturated
//   count : current value
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         CLK,
   input  logic         Reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge CLK) begin
      if (Reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule : sat_counter

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage of the single-cycle 9-bit core.
// Holds the PC, sequences start/run/halt and selects the next PC from a
// sequential increment or a taken branch.
//   CLK       : clock, rising edge
//   Reset     : synchronous active-high reset
//   Start     : begin execution at StartAddr (accepted in IDLE/HALTED only)
//   StartAddr : first instruction address
//   Halt      : Control HALT for the instruction at PC
//   Branch    : Control BRANCH for the instruction at PC
//   Taken     : ALU branch condition
//   Target    : absolute branch target
//   PC        : current instruction address to the ROM
//   InstValid : PC holds a live instruction this cycle
//   Done      : program has executed ht
//   InstCount : instructions retired since last accepted start, saturating
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int unsigned PC_W  = 10,
   parameter int unsigned CNT_W = 16
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             Start,
   input  logic [PC_W-1:0]  StartAddr,
   input  logic             Halt,
   input  logic             Branch,
   input  logic             Taken,
   input  logic [PC_W-1:0]  Target,
   output logic [PC_W-1:0]  PC,
   output logic             InstValid,
   output logic             Done,
   output logic [CNT_W-1:0] InstCount
);

   fetch_state_t    state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            cnt_clr;
   logic            cnt_inc;

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q <= IDLE;
         pc_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
      case (state_q)
         IDLE, HALTED: begin
            if (Start) begin
               state_d = RUN;
               pc_d    = StartAddr;
               cnt_clr = 1'b1;
            end
         end
         RUN: begin
            // Every RUN cycle retires one instruction, ht included.
            cnt_inc = 1'b1;
            if (Halt) begin
               state_d = HALTED;
            end else if (Branch && Taken) begin
               pc_d = Target;
            end else begin
               pc_d = pc_q + PC_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign PC        = pc_q;
   assign InstValid = (state_q == RUN);
   assign Done      = (state_q == HALTED);

   sat_counter #(
      .W (CNT_W)
   ) u_inst_count (
      .CLK   (CLK),
      .Reset (Reset),
      .clr   (cnt_clr),
      .inc   (cnt_inc),
      .count (InstCount)
   );

endmodule : fetch_unit
